lcd_velocidad_ctrl: RTL and testbench

Write sequencer for the velocimeter's character LCD (HD44780-style, 8-bit bus, write-only). Takes the five per-digit character codes from the digit-to-character encoder (thousands, hundreds, tens, units, tenths) and streams them to the display in one frame: cursor-address command, four integer digits, a decimal point, then the tenths digit. Frames start periodically or on request, and always begin from a snapshot of the inputs so the display never tears.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_pulso_escritura.sv | 96 +++++++++
 rtl/lcd_velocidad_ctrl.sv | 132 +++++++++++++
 tb/tb_lcd_velocidad_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared characters, FSM states and write-index helpers for the LCD write sequencer
package lcd_pkg;

    localparam logic [7:0] CHAR_CERO   = 8'h30;
    localparam logic [7:0] CHAR_BLANCO = 8'h20;
    localparam logic [7:0] CHAR_PUNTO  = 8'h2E;

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_ULTIMO = 3'd6;

    typedef enum logic [1:0] {IDLE, CARGA, EMITE, ESPERA} estado_e;
    typedef enum logic [1:0] {F_LIBRE, F_SETUP, F_PULSO, F_ESPERA} fase_e;

    typedef struct packed {
        logic [7:0] miles;
        logic [7:0] centenas;
        logic [7:0] decenas;
        logic [7:0] unidades;
        logic [7:0] decimal;
    } digitos_t;

    // Character carried by writes 1..6; write 0 is the address command and is handled by the caller.
    function automatic logic [7:0] caracter(input digitos_t s, input idx_t i);
        case (i)
            3'd1:    return s.miles;
            3'd2:    return s.centenas;
            3'd3:    return s.decenas;
            3'd4:    return s.unidades;
            3'd5:    return CHAR_PUNTO;
            default: return s.decimal;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pulso_escritura.sv
// rtl/lcd_pulso_escritura.sv - one LCD bus write: SETUP, EN_PULSE cycles of E high, WAIT_CYC cycles of hold
module lcd_pulso_escritura
    import lcd_pkg::*;
#(
    parameter int EN_PULSE = 12,
    parameter int WAIT_CYC = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic [7:0] data,
    input  logic       rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       hecho
);

    localparam int MAX_CYC = (EN_PULSE > WAIT_CYC) ? EN_PULSE : WAIT_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PULSO_FIN  = CNT_W'(EN_PULSE - 1);
    localparam logic [CNT_W-1:0] ESPERA_FIN = CNT_W'(WAIT_CYC - 1);

    fase_e            fase_q, fase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             hecho_q, hecho_d;

    always_comb begin
        fase_d = fase_q;
        cnt_d  = cnt_q;
        e_d    = e_q;
        data_d = data_q;
        rs_d   = rs_q;
        case (fase_q)
            F_SETUP: begin
                fase_d = F_PULSO;
                cnt_d  = '0;
                e_d    = 1'b1;
            end
            F_PULSO: begin
                if (cnt_q == PULSO_FIN) begin
                    fase_d = F_ESPERA;
                    cnt_d  = '0;
                    e_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            F_ESPERA: begin
                if (cnt_q == ESPERA_FIN) begin
                    fase_d = F_LIBRE;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // A new write may be chained in the last WAIT cycle, so SETUP follows with no gap.
        if (inicio) begin
            fase_d = F_SETUP;
            cnt_d  = '0;
            e_d    = 1'b0;
            data_d = data;
            rs_d   = rs;
        end
        hecho_d = (fase_d == F_ESPERA) && (cnt_d == ESPERA_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fase_q  <= F_LIBRE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            hecho_q <= 1'b0;
        end else begin
            fase_q  <= fase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            hecho_q <= hecho_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign hecho    = hecho_q;

endmodule

// File: rtl/lcd_velocidad_ctrl.sv
// rtl/lcd_velocidad_ctrl.sv - velocimeter LCD frame sequencer; LEADING_BLANK_EN enables leading-zero blanking
module lcd_velocidad_ctrl
    import lcd_pkg::*;
#(
    parameter int         EN_PULSE    = 12,
    parameter int         WAIT_CYC    = 2000,
    parameter int         REFRESH_CYC = 5_000_000,
    parameter logic [7:0] LINE_ADDR   = 8'h80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_listo,
    input  logic       actualizar,
    input  logic [7:0] dataMiles,
    input  logic [7:0] dataCentenas,
    input  logic [7:0] dataDecenas,
    input  logic [7:0] dataUnidades,
    input  logic [7:0] dataDecimal,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       ocupado
);

    localparam int TMR_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_FIN = TMR_W'(REFRESH_CYC - 1);

    estado_e          estado_q, estado_d;
    idx_t             idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             ocup_q, ocup_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    digitos_t         snap_q, snap_d;

    logic       expira, evento, inicio, hecho, wr_rs;
    logic [7:0] wr_data;

    assign expira = (tmr_q == TMR_FIN);
    assign evento = (actualizar | expira) & lcd_listo;

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        ocup_d   = ocup_q;
        snap_d   = snap_q;
        tmr_d    = expira ? '0 : tmr_q + TMR_W'(1);
        inicio   = 1'b0;
        wr_data  = LINE_ADDR;
        wr_rs    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (evento || (pend_q && lcd_listo)) begin
                    estado_d = CARGA;
                    ocup_d   = 1'b1;
                end
            end
            CARGA: begin
                snap_d = '{miles: dataMiles, centenas: dataCentenas, decenas: dataDecenas,
                           unidades: dataUnidades, decimal: dataDecimal};
`ifdef LEADING_BLANK_EN
                if (dataMiles == CHAR_CERO) begin
                    snap_d.miles = CHAR_BLANCO;
                    if (dataCentenas == CHAR_CERO) begin
                        snap_d.centenas = CHAR_BLANCO;
                        if (dataDecenas == CHAR_CERO) snap_d.decenas = CHAR_BLANCO;
                    end
                end
`endif
                pend_d   = 1'b0;
                idx_d    = '0;
                inicio   = 1'b1;
                estado_d = EMITE;
            end
            EMITE: estado_d = ESPERA;
            ESPERA: begin
                if (hecho) begin
                    if (idx_q == IDX_ULTIMO) begin
                        estado_d = IDLE;
                        ocup_d   = 1'b0;
                    end else begin
                        idx_d    = idx_q + idx_t'(1);
                        inicio   = 1'b1;
                        wr_data  = caracter(snap_q, idx_q + idx_t'(1));
                        wr_rs    = 1'b1;
                        estado_d = EMITE;
                    end
                end
            end
        endcase
        // Events during a frame (including its CARGA cycle) collapse into one follow-up frame.
        if (evento && ocup_q) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ocup_q   <= 1'b0;
            tmr_q    <= '0;
            snap_q   <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ocup_q   <= ocup_d;
            tmr_q    <= tmr_d;
            snap_q   <= snap_d;
        end
    end

    lcd_pulso_escritura #(
        .EN_PULSE (EN_PULSE),
        .WAIT_CYC (WAIT_CYC)
    ) u_pulso (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .data     (wr_data),
        .rs       (wr_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .hecho    (hecho)
    );

    assign lcd_rw  = 1'b0;
    assign ocupado = ocup_q;

endmodule

// File: tb/tb_lcd_velocidad_ctrl.sv
// tb/tb_lcd_velocidad_ctrl.sv - directed self-checking bench for lcd_velocidad_ctrl
module tb_lcd_velocidad_ctrl;

    localparam int EP = 2;
    localparam int WC = 4;
    localparam int RC = 1000;
`ifdef LEADING_BLANK_EN
    localparam logic BL = 1'b1;
`else
    localparam logic BL = 1'b0;
`endif
    localparam logic [7:0] Z = BL ? 8'h20 : 8'h30;

    logic       clk = 1'b0;
    logic       reset, lcd_listo, actualizar;
    logic [7:0] d_mil, d_cen, d_dec, d_uni, d_dcm;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, ocupado;

    int checks = 0;
    int errors = 0;
    int pc = 0;
    int cyc = 0, rises = 0, frames = 0, stab_err = 0;
    int occ_cnt = 0, occ_len = 0, fall_cyc = 0, rise_cyc = 0;
    int n, f0, r0;
    logic       e_prev = 1'b0, occ_prev = 1'b0, rs_prev = 1'b0;
    logic [7:0] d_prev = 8'h00;
    logic [8:0] wr_q [$];

    lcd_velocidad_ctrl #(
        .EN_PULSE    (EP),
        .WAIT_CYC    (WC),
        .REFRESH_CYC (RC),
        .LINE_ADDR   (8'h80)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_listo    (lcd_listo),
        .actualizar   (actualizar),
        .dataMiles    (d_mil),
        .dataCentenas (d_cen),
        .dataDecenas  (d_dec),
        .dataUnidades (d_uni),
        .dataDecimal  (d_dcm),
        .lcd_data     (lcd_data),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    // Independent model of the refresh timer: edges since the last reset edge.
    always @(posedge clk) begin
        if (reset) pc <= 0;
        else       pc <= pc + 1;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (lcd_e === 1'b1 && e_prev === 1'b0) begin
            wr_q.push_back({lcd_rs, lcd_data});
            rises <= rises + 1;
        end
        if (reset === 1'b0 && e_prev === 1'b1 && (lcd_data !== d_prev || lcd_rs !== rs_prev))
            stab_err <= stab_err + 1;
        if (ocupado === 1'b1) occ_cnt <= occ_cnt + 1;
        if (ocupado === 1'b1 && occ_prev === 1'b0) begin
            frames   <= frames + 1;
            rise_cyc <= cyc;
        end
        if (ocupado === 1'b0 && occ_prev === 1'b1) begin
            occ_len  <= occ_cnt;
            occ_cnt  <= 0;
            fall_cyc <= cyc;
        end
        e_prev   <= lcd_e;
        occ_prev <= ocupado;
        d_prev   <= lcd_data;
        rs_prev  <= lcd_rs;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse();
        actualizar = 1'b1;
        tick();
        actualizar = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] a, b, c, d, e);
        d_mil = a; d_cen = b; d_dec = c; d_uni = d; d_dcm = e;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (ocupado !== 1'b0 && k < 500) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 32'(k < 500), 1);
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] c1, c2, c3, c4, c6);
        logic [8:0] expv [7];
        expv[0] = {1'b0, 8'h80};
        expv[1] = {1'b1, c1};
        expv[2] = {1'b1, c2};
        expv[3] = {1'b1, c3};
        expv[4] = {1'b1, c4};
        expv[5] = {1'b1, 8'h2E};
        expv[6] = {1'b1, c6};
        chk({tag, "_nwr"}, wr_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < wr_q.size()) chk($sformatf("%s_w%0d", tag, i), 32'(wr_q[i]), 32'(expv[i]));
        wr_q.delete();
    endtask

    initial begin
        reset = 1'b1; lcd_listo = 1'b0; actualizar = 1'b0;
        set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_ocup", ocupado, 0);
        reset = 1'b0; lcd_listo = 1'b1;
        set_in(8'h30, 8'h31, 8'h32, 8'h33, 8'h35);
        tick();

        // Basic frame and trigger latency
        wr_q.delete();
        pulse();
        chk("t1_ocup_n", ocupado, 1);
        chk("t1_e_n", lcd_e, 0);
        tick();
        chk("t1_setup_data", lcd_data, 8'h80);
        chk("t1_setup_rs", lcd_rs, 0);
        chk("t1_setup_e", lcd_e, 0);
        tick();
        chk("t1_e_rise", lcd_e, 1);
        wait_idle("t1");
        chk("t1_len", occ_len, 50);
        chk_frame("t1", Z, 8'h31, 8'h32, 8'h33, 8'h35);

        // Snapshot isolation
        pulse();
        repeat (20) tick();
        set_in(8'h39, 8'h39, 8'h39, 8'h39, 8'h39);
        wait_idle("t2a");
        chk_frame("t2a", Z, 8'h31, 8'h32, 8'h33, 8'h35);
        pulse();
        wait_idle("t2b");
        chk_frame("t2b", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);

        // Several events during a frame, including a timer expiry at pc 999
        n = 0;
        while (pc < 970 && n < 2000) begin tick(); n++; end
        f0 = frames;
        pulse();
        repeat (10) tick();
        pulse();
        repeat (10) tick();
        pulse();
        wait_idle("t3a");
        chk_frame("t3a", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);
        n = 0;
        while (ocupado !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t3_gap", rise_cyc - fall_cyc, 1);
        wait_idle("t3b");
        chk_frame("t3b", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);
        repeat (60) tick();
        chk("t3_frames", frames - f0, 2);

        // lcd_listo low: running frame completes, triggers discarded
        pulse();
        repeat (5) tick();
        lcd_listo = 1'b0;
        repeat (5) tick();
        pulse();
        wait_idle("t4a");
        chk_frame("t4a", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);
        r0 = rises;
        f0 = frames;
        pulse();
        repeat (7) tick();
        pulse();
        n = 0;
        while (pc < 2030 && n < 2000) begin tick(); n++; end
        chk("t4_no_e", rises - r0, 0);
        lcd_listo = 1'b1;
        repeat (10) tick();
        chk("t4_no_pend", frames - f0, 0);
        pulse();
        chk("t4_start", ocupado, 1);
        wait_idle("t4b");
        chk_frame("t4b", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);

        // Reset during PULSE of write 3, then first automatic frame
        pulse();
        n = 0;
        while (!(wr_q.size() == 4 && lcd_e === 1'b1) && n < 200) begin tick(); n++; end
        chk("t5_reach", 32'(n < 200), 1);
        reset = 1'b1;
        tick();
        chk("t5_e", lcd_e, 0);
        chk("t5_ocup", ocupado, 0);
        chk("t5_data", lcd_data, 8'h00);
        chk("t5_rs", lcd_rs, 0);
        reset = 1'b0;
        wr_q.delete();
        n = 0;
        while (ocupado !== 1'b1 && n < 1100) begin tick(); n++; end
        chk("t5_auto_pc", pc, 1000);
        wait_idle("t5");
        chk("t5_len", occ_len, 50);
        chk_frame("t5", 8'h39, 8'h39, 8'h39, 8'h39, 8'h39);

        // Leading zeros (blanked only in the LEADING_BLANK_EN build)
        set_in(8'h30, 8'h30, 8'h35, 8'h30, 8'h30);
        pulse();
        wait_idle("t6a");
        chk_frame("t6a", Z, Z, 8'h35, 8'h30, 8'h30);
        set_in(8'h30, 8'h31, 8'h30, 8'h30, 8'h30);
        pulse();
        wait_idle("t6b");
        chk_frame("t6b", Z, 8'h31, 8'h30, 8'h30, 8'h30);

        chk("stable_bus", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
